// File: rtl/booth_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_pkg
// Description : Shared types and constants for the radix-2 Booth multiplier.
//               WIDTH : operand width (default 32)
//               AW    : accumulator / adder width
//               N     : number of Booth iterations
//               Macro BOOTH_MUL_UNSIGNED_EN widens AW and N by one so that
//               operands can be zero- or sign-extended to WIDTH+1 bits.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_mul_pkg;

  localparam int WIDTH = 32;

`ifdef BOOTH_MUL_UNSIGNED_EN
  localparam int AW = WIDTH + 2;
  localparam int N  = WIDTH + 1;
`else
  localparam int AW = WIDTH + 1;
  localparam int N  = WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth decode of {Q[0], q_1}
  localparam logic [1:0] PASS = 2'b00;
  localparam logic [1:0] ADD  = 2'b01;
  localparam logic [1:0] SUB  = 2'b10;

  function automatic logic [1:0] booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return PASS;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_mul32_if.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul32_if
// Description : Operand / product handshake bundle for booth_mul32.
//               master : producer/consumer side (drives in_valid, a, b,
//                        out_ready, and is_signed when BOOTH_MUL_UNSIGNED_EN)
//               slave  : multiplier side (drives in_ready, out_valid, product)
// Revision    : 1.0 - initial release
// ============================================================================
interface booth_mul32_if #(
  parameter int WIDTH = booth_mul_pkg::WIDTH
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
`ifdef BOOTH_MUL_UNSIGNED_EN
  logic               is_signed;

  modport master (output in_valid, a, b, is_signed, out_ready,
                  input  in_ready, out_valid, product);
  modport slave  (input  in_valid, a, b, is_signed, out_ready,
                  output in_ready, out_valid, product);
`else
  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, product);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, product);
`endif
endinterface
`default_nettype wire

// File: rtl/adder_cla_n.sv
`default_nettype none
// ============================================================================
// Module      : adder_cla_n
// Description : W-bit adder with carry-in built from 4-bit carry-lookahead
//               groups, rippling group carries.
//               x, y : addends      cin  : carry in
//               sum  : W-bit sum    cout : carry out of bit W-1
// Revision    : 1.0 - initial release
// ============================================================================
module adder_cla_n #(
  parameter int W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NG = (W + 3) / 4;
  localparam int WP = NG * 4;

  logic [WP-1:0] w_x_pad;
  logic [WP-1:0] w_y_pad;
  logic [WP-1:0] w_p;
  logic [WP-1:0] w_g;
  logic [NG:0]   w_gc;

  // Pad bits are forced to propagate (p=1, g=0) so the top group's carry-out
  // equals the true carry out of bit W-1.
  generate
    if (WP > W) begin : g_pad
      assign w_x_pad = {{(WP-W){1'b1}}, x};
      assign w_y_pad = {{(WP-W){1'b0}}, y};
    end else begin : g_nopad
      assign w_x_pad = x;
      assign w_y_pad = y;
    end
  endgenerate

  assign w_p     = w_x_pad ^ w_y_pad;
  assign w_g     = w_x_pad & w_y_pad;
  assign w_gc[0] = cin;
  assign cout    = w_gc[NG];

  // Carry into bit j of a group, expanded into sum-of-products by synthesis.
  function automatic logic carry_in(input logic [3:0] p, input logic [3:0] g,
                                    input logic c, input int j);
    logic r;
    r = c;
    for (int k = 0; k < j; k++) r = g[k] | (p[k] & r);
    return r;
  endfunction

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      localparam int B = gi * 4;
      logic [3:0] w_gp;
      logic [3:0] w_gg;
      logic       w_grp_p;
      logic       w_grp_g;

      assign w_gp    = w_p[B +: 4];
      assign w_gg    = w_g[B +: 4];
      assign w_grp_p = &w_gp;
      assign w_grp_g = w_gg[3]
                     | (w_gp[3] & w_gg[2])
                     | (w_gp[3] & w_gp[2] & w_gg[1])
                     | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);
      assign w_gc[gi+1] = w_grp_g | (w_grp_p & w_gc[gi]);

      for (genvar j = 0; j < 4; j++) begin : g_bit
        if (B + j < W) begin : g_sum
          assign sum[B+j] = w_gp[j] ^ carry_in(w_gp, w_gg, w_gc[gi], j);
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/booth_mul32.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul32
// Description : Multi-cycle radix-2 Booth multiplier, one iteration per clock.
//               clk, rst_n : clock, asynchronous active-low reset
//               bus        : booth_mul32_if.slave (in_valid/in_ready, a, b,
//                            out_valid/out_ready, product; is_signed when
//                            BOOTH_MUL_UNSIGNED_EN is defined)
//               Latency N cycles from acceptance to out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mul32
  import booth_mul_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  booth_mul32_if.slave bus
);

  localparam int QW = N;
  localparam int CW = $clog2(N + 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [AW-1:0]  r_a;
  logic [AW-1:0]  r_m;
  logic [QW-1:0]  r_q;
  logic           r_q1;
  logic [CW-1:0]  r_cnt;

  logic [AW-1:0]  w_m_load;
  logic [QW-1:0]  w_q_load;
  logic [1:0]     w_op;
  logic           w_sub;
  logic [AW-1:0]  w_add_y;
  logic [AW-1:0]  w_sum;
  logic [AW-1:0]  w_a_nxt;
  logic           w_accept;
  logic           w_cout_unused;

`ifdef BOOTH_MUL_UNSIGNED_EN
  logic w_a_top;
  logic w_b_top;
  assign w_a_top  = bus.is_signed & bus.a[WIDTH-1];
  assign w_b_top  = bus.is_signed & bus.b[WIDTH-1];
  assign w_m_load = {w_a_top, w_a_top, bus.a};
  assign w_q_load = {w_b_top, bus.b};
`else
  assign w_m_load = {bus.a[WIDTH-1], bus.a};
  assign w_q_load = bus.b;
`endif

  assign w_accept = (r_state == IDLE) && bus.in_valid;

  // Datapath: subtraction is A + ~M + 1 through the adder's carry-in.
  assign w_op    = booth_decode(r_q[0], r_q1);
  assign w_sub   = (w_op == SUB);
  assign w_add_y = w_sub ? ~r_m : r_m;

  adder_cla_n #(.W(AW)) u_adder (
    .x    (r_a),
    .y    (w_add_y),
    .cin  (w_sub),
    .sum  (w_sum),
    .cout (w_cout_unused)
  );

  assign w_a_nxt = (w_op == PASS) ? r_a : w_sum;

  // Low 2*WIDTH bits of {A, Q}
  assign bus.product = {r_a[2*WIDTH-QW-1:0], r_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = CALC;
      end
      CALC: begin
        if (r_cnt == CW'(1)) w_state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_m   <= '0;
      r_q   <= '0;
      r_q1  <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= '0;
      r_m   <= w_m_load;
      r_q   <= w_q_load;
      r_q1  <= 1'b0;
      r_cnt <= CW'(N);
    end else if (r_state == CALC) begin
      // Arithmetic right shift of {A, Q, q_1}
      r_a   <= {w_a_nxt[AW-1], w_a_nxt[AW-1:1]};
      r_q   <= {w_a_nxt[0], r_q[QW-1:1]};
      r_q1  <= r_q[0];
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_mul32.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mul32
// Description : Directed self-checking bench for booth_mul32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mul32;

`ifdef BOOTH_MUL_UNSIGNED_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 32;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  booth_mul32_if bus ();

  booth_mul32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after the acceptance edge; returns cycles until out_valid.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic is_s, input logic [63:0] exp);
    int cyc;
    @(negedge clk);
`ifdef BOOTH_MUL_UNSIGNED_EN
    bus.is_signed = is_s;
`else
    if (!is_s) $display("note: unsigned vector skipped in signed-only build");
`endif
    bus.a = ta;
    bus.b = tb_v;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
`ifdef BOOTH_MUL_UNSIGNED_EN
    bus.is_signed = ~is_s;
`endif
    wait_done(cyc);
    chk({tag, "_lat"}, 64'(cyc), 64'(LAT));
    chk({tag, "_prod"}, bus.product, exp);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_idle"}, {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
  endtask

  initial begin
    int   cyc;
    logic seen;
    checks = 0;
    errors = 0;

    // Reset held with in_valid asserted
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 32'd3;
    bus.b         = 32'hFFFF_FFFB;
    bus.out_ready = 1'b0;
`ifdef BOOTH_MUL_UNSIGNED_EN
    bus.is_signed = 1'b1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_product", bus.product, 64'd0);

    // Release: no acceptance before the next edge
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("acc_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    wait_done(cyc);
    chk("s3m5_lat", 64'(cyc), 64'(LAT));
    chk("s3m5_prod", bus.product, 64'hFFFF_FFFF_FFFF_FFF1);

    // Backpressure with toggling inputs
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.a = $urandom;
      bus.b = $urandom;
      @(posedge clk);
      #1;
      chk("bp_prod", bus.product, 64'hFFFF_FFFF_FFFF_FFF1);
      chk("bp_flags", {62'd0, bus.in_ready, bus.out_valid}, 64'b01);
    end
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("bp_release", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);

    do_op("minmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    do_op("min1",   32'h8000_0000, 32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000);
    do_op("maxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001);
    do_op("m1m1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);
    do_op("zero",   32'd0,         32'h1234_5678, 1'b1, 64'd0);

    // Reset mid-operation
    @(negedge clk);
    bus.a = 32'd100;
    bus.b = 32'd100;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_flags", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
    chk("abort_product", bus.product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);
    do_op("s7x6", 32'd7, 32'd6, 1'b1, 64'd42);

`ifdef BOOTH_MUL_UNSIGNED_EN
    do_op("u_ffx2", 32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE);
    do_op("s_ffx2", 32'hFFFF_FFFF, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op("u_maxsq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
